// File: rtl/sync_sdiv.sv
// Iterative restoring signed divider: 2N-bit dividend / N-bit divisor, fixed N+2 cycle latency.
// Optional macro SDIV_SAT_EN saturates the quotient on overflow instead of forcing it to zero.
module sync_sdiv #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           ovf,
  output logic           dbz
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] QMAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] QMAX_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic [N-1:0]    quo_q, quo_d, rout_q, rout_d;
  logic            pre_ovf_q, pre_ovf_d, pre_dbz_q, pre_dbz_d, sq_q, sq_d, sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    rem_q, rem_d, lo_q, lo_d, qmag_q, qmag_d;
  logic [N:0]      dmag_q, dmag_d;

  logic [2*N-1:0]  dvd_mag_s;
  logic [N:0]      dsr_mag_s, shifted_s, diff_s;
  logic            range_ovf_s, all_ovf_s, sat_neg_s;

  // Next-state, datapath step and output formatting
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
    quo_d     = quo_q;
    rout_d    = rout_q;
    pre_ovf_d = pre_ovf_q;
    pre_dbz_d = pre_dbz_q;
    sq_d      = sq_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    lo_d      = lo_q;
    qmag_d    = qmag_q;
    dmag_d    = dmag_q;

    dvd_mag_s = dividend[2*N-1] ? ({(2*N){1'b0}} - dividend) : dividend;
    dsr_mag_s = divisor[N-1] ? ({(N+1){1'b0}} - {divisor[N-1], divisor}) : {1'b0, divisor};
    shifted_s = {rem_q, lo_q[N-1]};
    diff_s    = shifted_s - dmag_q;

    range_ovf_s = sq_q ? (qmag_q > QMAX_NEG) : (qmag_q > QMAX_POS);
    all_ovf_s   = pre_ovf_q | range_ovf_s;
    // A zero divisor carries no sign, so saturation follows the dividend
    sat_neg_s   = pre_dbz_q ? sr_q : sq_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !busy_q) begin
          busy_d    = 1'b1;
          sq_d      = dividend[2*N-1] ^ divisor[N-1];
          sr_d      = dividend[2*N-1];
          dmag_d    = dsr_mag_s;
          rem_d     = dvd_mag_s[2*N-1:N];
          lo_d      = dvd_mag_s[N-1:0];
          qmag_d    = {N{1'b0}};
          cnt_d     = CW'(N);
          pre_dbz_d = (divisor == {N{1'b0}});
          pre_ovf_d = ({1'b0, dvd_mag_s[2*N-1:N]} >= dsr_mag_s) || (divisor == {N{1'b0}});
          state_d   = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // Remainder stays below the divisor magnitude, so N bits hold it after the step
        if (shifted_s >= dmag_q) begin
          rem_d  = diff_s[N-1:0];
          qmag_d = {qmag_q[N-2:0], 1'b1};
        end else begin
          rem_d  = shifted_s[N-1:0];
          qmag_d = {qmag_q[N-2:0], 1'b0};
        end
        lo_d  = {lo_q[N-2:0], 1'b0};
        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        done_d = 1'b1;
        ovf_d  = all_ovf_s;
        dbz_d  = pre_dbz_q;
        if (all_ovf_s) begin
`ifdef SDIV_SAT_EN
          quo_d = sat_neg_s ? QMAX_NEG : QMAX_POS;
`else
          quo_d = {N{1'b0}};
`endif
          rout_d = {N{1'b0}};
        end else begin
          quo_d  = sq_q ? ({N{1'b0}} - qmag_q) : qmag_q;
          rout_d = sr_q ? ({N{1'b0}} - rem_q) : rem_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
      quo_q     <= {N{1'b0}};
      rout_q    <= {N{1'b0}};
      pre_ovf_q <= 1'b0;
      pre_dbz_q <= 1'b0;
      sq_q      <= 1'b0;
      sr_q      <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      rem_q     <= {N{1'b0}};
      lo_q      <= {N{1'b0}};
      qmag_q    <= {N{1'b0}};
      dmag_q    <= {(N+1){1'b0}};
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      dbz_q     <= dbz_d;
      quo_q     <= quo_d;
      rout_q    <= rout_d;
      pre_ovf_q <= pre_ovf_d;
      pre_dbz_q <= pre_dbz_d;
      sq_q      <= sq_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      lo_q      <= lo_d;
      qmag_q    <= qmag_d;
      dmag_q    <= dmag_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;
  assign quotient  = quo_q;
  assign remainder = rout_q;

endmodule

// File: doc/sync_sdiv.md
Name: sync_sdiv

Overview:
- Iterative signed divider; the inverse of the team's synchronized signed multiplier.
- Divides a 2N-bit signed dividend (multiplier product width) by an N-bit signed divisor, giving an N-bit signed quotient and an N-bit signed remainder.
- Sits beside the multiplier in the pico-MIPS datapath.
- Uses a start/busy/done handshake with fixed latency.

Parameters:
N, 8, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits.

Ports:
clk  input  1  system clock, rising edge
n_reset  input  1  asynchronous active-low reset
start  input  1  request; sampled only while busy=0
dividend  input  2N  signed dividend, captured when start accepted
divisor  input  N  signed divisor, captured when start accepted
busy  output  1  high from cycle after acceptance until done cycle inclusive
done  output  1  single-cycle pulse; results valid from this cycle
quotient  output  N  signed quotient, truncated toward zero
remainder  output  N  signed remainder, sign follows dividend
ovf  output  1  quotient not representable in N signed bits, or divide by zero
dbz  output  1  divisor was zero

Behaviour:
- Reset (n_reset=0, asynchronous): state IDLE; busy, done, ovf, dbz = 0; quotient, remainder = 0.
- Reset mid-operation aborts the division with no done pulse.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 captures operands into registers.
  - Stores magnitudes |dividend| (2N bits), |divisor| (N+1 bits internal, so -2^(N-1) is handled).
  - Stores sign flags: sq = sign(dividend) XOR sign(divisor); sr = sign(dividend).
  - Loads iteration counter = N, then goes to CALC.
- Pre-check at acceptance (unsigned):
  - Overflow flag set if upper N bits of |dividend| >= |divisor|.
  - Overflow flag set if divisor == 0.
  - dbz flag set if divisor == 0.
- CALC: one restoring-division step per cycle, exactly N cycles.
  - Shift partial remainder left by 1 and bring in the next dividend bit.
  - Subtract |divisor| if the result is non-negative, setting quotient bit.
  - Partial remainder is N+1 bits.
- FIX, one cycle:
  - Apply signs: quotient = sq ? -qmag : qmag; remainder = sr ? -rmag : rmag.
  - Signed range check: qmag > 2^(N-1)-1 when sq=0, or qmag > 2^(N-1) when sq=1, sets the overflow flag.
  - Register the outputs.
  - Assert done and ovf/dbz.
  - Return to IDLE.
- Latency: start accepted at cycle T → done=1 at cycle T+N+2, for all cases including ovf/dbz. Iteration runs regardless; outputs are overridden.
- On ovf (feature off): quotient = 0, remainder = 0.
- Outputs hold until the next done; ovf and dbz likewise.
- done is never asserted for two consecutive cycles.
- start while busy=1: ignored; no queuing, no effect on the current operation.
- start in the done cycle: accepted (busy deasserts in the same cycle the FSM reaches IDLE?). No: done coincides with FIX→IDLE, so start is accepted on the next cycle when busy=0. Back-to-back throughput is one result per N+3 cycles.

Optional Feature:
- Macro: SDIV_SAT_EN.
- Defined: on ovf, quotient saturates to 2^(N-1)-1 when sq=0, or -2^(N-1) when sq=1. For divide by zero, saturation sign follows the dividend sign. Remainder = 0.
- Undefined: on ovf, quotient = 0, remainder = 0.
- In both builds, ovf/dbz flags and latency are unchanged.

Test Plan:
- N=8, dividend=16'd100, divisor=8'd7 → done at T+10; quotient=8'h0E, remainder=8'h02, ovf=0.
- dividend=-100 (16'hFF9C), divisor=7 → quotient=8'hF2 (-14), remainder=8'hFE (-2), ovf=0.
- dividend=16'hFF80 (-128), divisor=1 → quotient=8'h80, ovf=0. dividend=16'h0080, divisor=1 → ovf=1, quotient=8'h00 (8'h7F with SDIV_SAT_EN).
- divisor=0, dividend=16'd5 → done at T+10, dbz=1, ovf=1, quotient=0 (8'h7F with SDIV_SAT_EN).
- Second start pulse with different operands at T+3 → ignored; single done at T+10 with the first operation's result; busy high T+1..T+10.
- n_reset low at T+5 → all outputs 0 immediately; no done pulse. New start after release → correct result at its own T'+10.
